// File: rtl/pulse_pkg.sv
// Shared constants and types for the multi-channel pulse generator.
package pulse_pkg;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RETRIG  = 1'b1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    // Depth of the trigger synchroniser chain.
    function automatic int unsigned sync_depth();
        return 2;
    endfunction

endpackage

// File: rtl/pulse_chan.sv
// One pulse channel: trigger synchroniser, debounce filter, press-edge detect
// and the IDLE/ACTIVE pulse FSM.
module pulse_chan
    import pulse_pkg::*;
#(
    parameter int unsigned LEN_W           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             trig_n,
    input  logic             retrig,
    input  logic [LEN_W-1:0] pulse_len,
    input  logic             clr_missed,
    output logic             pulse_out,
    output logic             done,
    output logic             missed
);

    localparam int unsigned SYNC_DEPTH = sync_depth();
    localparam int unsigned DB_W       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  s2_c;
    logic [DB_W-1:0]       db_cnt_q;
    logic                  filt_q;
    logic                  filt_dly_q;
    logic                  event_c;

    state_e                state_q, state_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic                  pulse_d, done_d, missed_d;
    logic                  miss_set_c, reload_c, len_ok_c;

    // Synchroniser resets to the released level so reset exit is never a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], trig_n};
        end
    end

    assign s2_c = sync_q[SYNC_DEPTH-1];

    // Level is accepted once the synchronised input disagrees for DEBOUNCE_CYCLES samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q   <= '0;
            filt_q     <= 1'b1;
            filt_dly_q <= 1'b1;
        end else begin
            filt_dly_q <= filt_q;
            if (s2_c == filt_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
                filt_q   <= s2_c;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
            end
        end
    end

    assign event_c  = en & filt_dly_q & ~filt_q;
    assign len_ok_c = (pulse_len != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pulse_out <= 1'b0;
            done      <= 1'b0;
            missed    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pulse_out <= pulse_d;
            done      <= done_d;
            missed    <= missed_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pulse_d    = pulse_out;
        done_d     = 1'b0;
        miss_set_c = 1'b0;
        reload_c   = 1'b0;

        case (retrig)
            MODE_RETRIG:  reload_c = event_c & len_ok_c;
            MODE_ONESHOT: reload_c = 1'b0;
        endcase

        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            pulse_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (event_c && len_ok_c) begin
                        state_d = ACTIVE;
                        cnt_d   = pulse_len - LEN_W'(1);
                        pulse_d = 1'b1;
                    end else if (event_c) begin
                        miss_set_c = 1'b1;
                    end
                end
                ACTIVE: begin
                    // A reload beats expiry in the same cycle, so no done strobe.
                    if (reload_c) begin
                        cnt_d = pulse_len - LEN_W'(1);
                    end else begin
                        miss_set_c = event_c;
                        if (cnt_q == '0) begin
                            state_d = IDLE;
                            pulse_d = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q - LEN_W'(1);
                        end
                    end
                end
            endcase
        end

        missed_d = miss_set_c | (missed & ~clr_missed);
    end

endmodule

// File: rtl/pulse_gen_mc.sv
// Multi-channel one-shot pulse generator: one pulse_chan per trigger input.
module pulse_gen_mc
    import pulse_pkg::*;
#(
    parameter int unsigned N_CH            = 2,
    parameter int unsigned LEN_W           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       en,
    input  logic [N_CH-1:0]       trig_n,
    input  logic [N_CH-1:0]       retrig,
    input  logic [N_CH*LEN_W-1:0] pulse_len,
    input  logic                  clr_missed,
    output logic [N_CH-1:0]       pulse_out,
    output logic [N_CH-1:0]       done,
    output logic [N_CH-1:0]       missed
);

    for (genvar i = 0; i < int'(N_CH); i++) begin : g_chan
        pulse_chan #(
            .LEN_W           (LEN_W),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en[i]),
            .trig_n     (trig_n[i]),
            .retrig     (retrig[i]),
            .pulse_len  (pulse_len[i*LEN_W +: LEN_W]),
            .clr_missed (clr_missed),
            .pulse_out  (pulse_out[i]),
            .done       (done[i]),
            .missed     (missed[i])
        );
    end

endmodule

// File: tb/tb_pulse_gen_mc.sv
// Self-checking bench for pulse_gen_mc: directed scenarios plus randomized
// triggers, compared every cycle against a behavioural reference model.
module tb_pulse_gen_mc;

    localparam int unsigned N_CH  = 2;
    localparam int unsigned LEN_W = 8;
    localparam int unsigned DC    = 4;

    logic                  clk;
    logic                  rst_n;
    logic [N_CH-1:0]       en;
    logic [N_CH-1:0]       trig_n;
    logic [N_CH-1:0]       retrig;
    logic [N_CH*LEN_W-1:0] pulse_len;
    logic                  clr_missed;
    logic [N_CH-1:0]       pulse_out;
    logic [N_CH-1:0]       done;
    logic [N_CH-1:0]       missed;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // Reference model state: sync samples, last DC debounce inputs, accepted level,
    // and remaining high cycles of the current pulse.
    bit              m_s1    [N_CH];
    bit              m_s2    [N_CH];
    bit              m_filt  [N_CH];
    bit              m_filtq [N_CH];
    bit [DC-1:0]     m_hist  [N_CH];
    int              m_rem   [N_CH];
    logic [N_CH-1:0] m_pulse, m_done, m_missed;

    pulse_gen_mc #(
        .N_CH            (N_CH),
        .LEN_W           (LEN_W),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .trig_n     (trig_n),
        .retrig     (retrig),
        .pulse_len  (pulse_len),
        .clr_missed (clr_missed),
        .pulse_out  (pulse_out),
        .done       (done),
        .missed     (missed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int c = 0; c < int'(N_CH); c++) begin
            m_s1[c]    = 1'b1;
            m_s2[c]    = 1'b1;
            m_filt[c]  = 1'b1;
            m_filtq[c] = 1'b1;
            m_hist[c]  = '1;
            m_rem[c]   = 0;
        end
        m_pulse  = '0;
        m_done   = '0;
        m_missed = '0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int c = 0; c < int'(N_CH); c++) begin
            bit db_in, ev, set;
            int len;
            db_in      = m_s2[c];
            m_s2[c]    = m_s1[c];
            m_s1[c]    = trig_n[c];
            ev         = en[c] && m_filtq[c] && !m_filt[c];
            m_filtq[c] = m_filt[c];
            m_hist[c]  = {m_hist[c][DC-2:0], db_in};
            if (m_hist[c] == {DC{~m_filt[c]}}) m_filt[c] = ~m_filt[c];

            len       = int'(pulse_len[c*LEN_W +: LEN_W]);
            set       = 1'b0;
            m_done[c] = 1'b0;
            if (!en[c]) begin
                m_pulse[c] = 1'b0;
                m_rem[c]   = 0;
            end else if (ev && !m_pulse[c] && len != 0) begin
                m_pulse[c] = 1'b1;
                m_rem[c]   = len;
            end else if (ev && m_pulse[c] && retrig[c] && len != 0) begin
                m_rem[c] = len;
            end else begin
                if (ev) set = 1'b1;
                if (m_pulse[c]) begin
                    m_rem[c]--;
                    if (m_rem[c] == 0) begin
                        m_pulse[c] = 1'b0;
                        m_done[c]  = 1'b1;
                    end
                end
            end
            if (set) m_missed[c] = 1'b1;
            else if (clr_missed) m_missed[c] = 1'b0;
        end
    endtask

    // One clock: edge, model update, then return at the falling edge for sampling.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        en         = '1;
        trig_n     = '1;
        retrig     = '0;
        pulse_len  = {8'd10, 8'd10};
        clr_missed = 1'b0;
        model_reset();
        repeat (3) step();
        vectors++;
        if ({pulse_out, done, missed} !== 6'b0)
            $display("FAIL reset_hold got=%b want=000000", {pulse_out, done, missed});
        if ({pulse_out, done, missed} !== 6'b0) errors++;
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            vectors++;
            if ({pulse_out, done, missed} !== 6'b0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%b want=000000", cyc, {pulse_out, done, missed});
            end
        end
    endtask

    task automatic test_single();
        int first = -1, width = 0, dones = 0, ch1 = 0;
        pulse_len[7:0] = 8'd10;
        trig_n[0] = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 21) trig_n[0] = 1'b1;
            step();
            vectors++;
            if ({pulse_out, done, missed} !== {m_pulse, m_done, m_missed}) begin
                errors++;
                $display("FAIL single cyc=%0d got=%b want=%b", cyc, {pulse_out, done, missed}, {m_pulse, m_done, m_missed});
            end
            if (pulse_out[0] && first < 0) first = i;
            if (pulse_out[0]) width++;
            if (done[0]) dones++;
            if (pulse_out[1] || done[1]) ch1++;
        end
        vectors++;
        if (first != 7) begin errors++; $display("FAIL single_latency got=%0d want=7", first); end
        vectors++;
        if (width != 10) begin errors++; $display("FAIL single_width got=%0d want=10", width); end
        vectors++;
        if (dones != 1) begin errors++; $display("FAIL single_done got=%0d want=1", dones); end
        vectors++;
        if (ch1 != 0) begin errors++; $display("FAIL single_ch1 got=%0d want=0", ch1); end
    endtask

    task automatic test_glitch();
        int highs = 0;
        trig_n[0] = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            if (i == 4) trig_n[0] = 1'b1;
            step();
            vectors++;
            if ({pulse_out, done, missed} !== {m_pulse, m_done, m_missed}) begin
                errors++;
                $display("FAIL glitch cyc=%0d got=%b want=%b", cyc, {pulse_out, done, missed}, {m_pulse, m_done, m_missed});
            end
            if (pulse_out[0]) highs++;
        end
        vectors++;
        if (highs != 0 || missed[0] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_nopulse got highs=%0d missed=%b want 0/0", highs, missed[0]);
        end
    endtask

    // Press, release, re-press: second event lands 8 cycles into the pulse.
    task automatic double_press(input bit mode, output int width, output int dones);
        width = 0;
        dones = 0;
        retrig[0] = mode;
        pulse_len[7:0] = 8'd10;
        for (int i = 1; i <= 45; i++) begin
            trig_n[0] = !((i >= 1 && i <= 4) || (i >= 9 && i <= 16));
            step();
            vectors++;
            if ({pulse_out, done, missed} !== {m_pulse, m_done, m_missed}) begin
                errors++;
                $display("FAIL double_press mode=%0d cyc=%0d got=%b want=%b", mode, cyc, {pulse_out, done, missed}, {m_pulse, m_done, m_missed});
            end
            if (pulse_out[0]) width++;
            if (done[0]) dones++;
        end
    endtask

    task automatic test_oneshot();
        int width, dones;
        double_press(1'b0, width, dones);
        vectors++;
        if (width != 10 || dones != 1) begin
            errors++;
            $display("FAIL oneshot_width got=%0d/%0d want=10/1", width, dones);
        end
        vectors++;
        if (missed[0] !== 1'b1) begin errors++; $display("FAIL oneshot_missed got=%b want=1", missed[0]); end
        clr_missed = 1'b1;
        step();
        clr_missed = 1'b0;
        vectors++;
        if (missed !== 2'b00 || m_missed !== 2'b00) begin
            errors++;
            $display("FAIL clr_missed got=%b want=00", missed);
        end
    endtask

    task automatic test_retrig();
        int width, dones;
        double_press(1'b1, width, dones);
        vectors++;
        if (width != 18 || dones != 1) begin
            errors++;
            $display("FAIL retrig_width got=%0d/%0d want=18/1", width, dones);
        end
        vectors++;
        if (missed[0] !== 1'b0) begin errors++; $display("FAIL retrig_missed got=%b want=0", missed[0]); end
        retrig[0] = 1'b0;
    endtask

    task automatic test_async_reset();
        trig_n[0] = 1'b0;
        repeat (9) step();
        vectors++;
        if (pulse_out[0] !== 1'b1) begin errors++; $display("FAIL areset_pre got=%b want=1", pulse_out[0]); end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (pulse_out !== 2'b00) begin errors++; $display("FAIL areset_now got=%b want=00", pulse_out); end
        model_reset();
        trig_n = '1;
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            vectors++;
            if ({pulse_out, done, missed} !== {m_pulse, m_done, m_missed}) begin
                errors++;
                $display("FAIL areset_after cyc=%0d got=%b want=%b", cyc, {pulse_out, done, missed}, {m_pulse, m_done, m_missed});
            end
        end
    endtask

    task automatic test_en_low();
        int highs = 0;
        trig_n[0] = 1'b0;
        repeat (9) step();
        en[0] = 1'b0;
        step();
        vectors++;
        if (pulse_out[0] !== 1'b0 || done[0] !== 1'b0) begin
            errors++;
            $display("FAIL en_low got=%b%b want=00", pulse_out[0], done[0]);
        end
        repeat (3) step();
        en[0] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i == 10) trig_n[0] = 1'b1;
            step();
            vectors++;
            if ({pulse_out, done, missed} !== {m_pulse, m_done, m_missed}) begin
                errors++;
                $display("FAIL en_reenable cyc=%0d got=%b want=%b", cyc, {pulse_out, done, missed}, {m_pulse, m_done, m_missed});
            end
            if (pulse_out[0]) highs++;
        end
        vectors++;
        if (highs != 0) begin errors++; $display("FAIL en_held_refire got=%0d want=0", highs); end
    endtask

    task automatic test_len_zero();
        int highs = 0;
        pulse_len[7:0] = 8'd0;
        trig_n[0] = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 12) trig_n[0] = 1'b1;
            step();
            vectors++;
            if ({pulse_out, done, missed} !== {m_pulse, m_done, m_missed}) begin
                errors++;
                $display("FAIL len_zero cyc=%0d got=%b want=%b", cyc, {pulse_out, done, missed}, {m_pulse, m_done, m_missed});
            end
            if (pulse_out[0]) highs++;
        end
        vectors++;
        if (highs != 0 || missed[0] !== 1'b1) begin
            errors++;
            $display("FAIL len_zero_missed got highs=%0d missed=%b want 0/1", highs, missed[0]);
        end
        clr_missed = 1'b1;
        step();
        clr_missed = 1'b0;
    endtask

    task automatic test_random();
        int hold [N_CH];
        for (int c = 0; c < int'(N_CH); c++) hold[c] = 1;
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < int'(N_CH); c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    trig_n[c] = ~trig_n[c];
                    hold[c]   = int'($urandom_range(1, 14));
                end
                if ($urandom_range(0, 40) == 0) en[c] = ~en[c];
                if (!en[c] && $urandom_range(0, 3) == 0) en[c] = 1'b1;
                if ($urandom_range(0, 30) == 0) retrig[c] = 1'($urandom);
                if ($urandom_range(0, 25) == 0)
                    pulse_len[c*LEN_W +: LEN_W] = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 24));
            end
            clr_missed = ($urandom_range(0, 30) == 0);
            step();
            vectors++;
            if ({pulse_out, done, missed} !== {m_pulse, m_done, m_missed}) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b want=%b", cyc, {pulse_out, done, missed}, {m_pulse, m_done, m_missed});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_oneshot();
        test_retrig();
        test_async_reset();
        test_en_low();
        test_len_zero();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
